// File: rtl/ir_nec_rx_param.sv
// NEC infrared frame receiver for the miniCar remote-control path.
// Synchronises the demodulated IR line, measures mark/space lengths in
// fixed ticks, decodes 32-bit NEC frames and repeat codes, and checks the
// inverse bytes. Repeat codes are accepted only within a time window that
// opens after a valid frame or repeat.
module ir_nec_rx_param #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TICK_NS    = 35_000,
  parameter logic        IR_ACT_LVL = 1'b1,
  parameter bit          CHECK_INV  = 1'b1,
  parameter bit          EXT_ADDR   = 1'b0,
  parameter int unsigned REPEAT_MS  = 120
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        ir_in,
  output logic        frame_valid,
  output logic        repeat_valid,
  output logic [15:0] address,
  output logic [7:0]  command,
  output logic [31:0] raw_frame,
  output logic        frame_err,
  output logic        busy
);

  localparam longint unsigned DIV_L =
    (longint'(CLK_HZ) * longint'(TICK_NS)) / 64'd1_000_000_000;
  localparam longint unsigned MS_DIV_L = longint'(CLK_HZ) / 64'd1000;
  localparam logic [31:0] TICK_LAST = (DIV_L > 64'd1) ? 32'(DIV_L - 64'd1) : 32'd0;
  localparam logic [31:0] MS_LAST   = (MS_DIV_L > 64'd1) ? 32'(MS_DIV_L - 64'd1) : 32'd0;
  localparam logic [15:0] RPT_LOAD  = 16'(REPEAT_MS);
  localparam logic [8:0]  TICK_MAX  = 9'd511;

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_RPT_STOP, S_DONE
  } state_t;

  state_t      state;
  logic        sync1, sync2, line_q, edge_r;
  logic        mark;
  logic [31:0] tick_pre;
  logic [8:0]  tick_cnt;
  logic [31:0] ms_pre;
  logic [15:0] ms_cnt;
  logic        win_open;
  logic [31:0] shreg;
  logic [4:0]  bit_cnt;
  logic        cmd_ok, addr_ok, inv_ok;

  // Exclusive-bound window test on a measured length in ticks.
  function automatic logic in_win(input logic [8:0] t, input logic [8:0] lo,
                                  input logic [8:0] hi);
    return (t > lo) && (t < hi);
  endfunction

  assign mark     = (line_q == IR_ACT_LVL);
  assign win_open = (ms_cnt != 16'd0);
  assign busy     = (state != S_IDLE);
  assign cmd_ok   = (shreg[31:24] == ~shreg[23:16]);
  assign addr_ok  = EXT_ADDR || (shreg[15:8] == ~shreg[7:0]);
  assign inv_ok   = !CHECK_INV || (cmd_ok && addr_ok);

  // Two-flop synchroniser, then a registered copy of the line and an edge flag.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      line_q <= 1'b0;
      edge_r <= 1'b0;
    end else begin
      sync1  <= ir_in;
      sync2  <= sync1;
      line_q <= sync2;
      edge_r <= sync2 ^ line_q;
    end
  end

  // Tick prescaler and saturating length counter; any edge restarts both.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      tick_pre <= 32'd0;
      tick_cnt <= 9'd0;
    end else if (edge_r) begin
      tick_pre <= 32'd0;
      tick_cnt <= 9'd0;
    end else if (tick_pre >= TICK_LAST) begin
      tick_pre <= 32'd0;
      if (tick_cnt != TICK_MAX) tick_cnt <= tick_cnt + 9'd1;
    end else begin
      tick_pre <= tick_pre + 32'd1;
    end
  end

  // Millisecond countdown that keeps the repeat window open after a good frame.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      ms_pre <= 32'd0;
      ms_cnt <= 16'd0;
    end else begin
      if (ms_pre >= MS_LAST) ms_pre <= 32'd0;
      else                   ms_pre <= ms_pre + 32'd1;
      if (frame_valid || repeat_valid)          ms_cnt <= RPT_LOAD;
      else if (frame_err)                       ms_cnt <= 16'd0;
      else if (ms_pre >= MS_LAST && win_open)   ms_cnt <= ms_cnt - 16'd1;
    end
  end

  // Frame decoder: judges each measured length at its terminating edge.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      frame_valid  <= 1'b0;
      repeat_valid <= 1'b0;
      frame_err    <= 1'b0;
      address      <= 16'd0;
      command      <= 8'd0;
      raw_frame    <= 32'd0;
      shreg        <= 32'd0;
      bit_cnt      <= 5'd0;
    end else begin
      frame_valid  <= 1'b0;
      repeat_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (state != S_IDLE && !edge_r && tick_cnt == TICK_MAX) begin
        frame_err <= 1'b1;
        state     <= S_IDLE;
      end else if (edge_r) begin
        case (state)
          S_IDLE: begin
            if (mark) state <= S_LEAD_MARK;
          end
          S_LEAD_MARK: begin
            if (in_win(tick_cnt, 9'd217, 9'd297)) begin
              state <= S_LEAD_SPACE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
            end
          end
          S_LEAD_SPACE: begin
            if (in_win(tick_cnt, 9'd88, 9'd168)) begin
              bit_cnt <= 5'd0;
              state   <= S_BIT_MARK;
            end else if (in_win(tick_cnt, 9'd44, 9'd84)) begin
              state <= S_RPT_STOP;
            end else begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
            end
          end
          S_BIT_MARK: begin
            if (in_win(tick_cnt, 9'd6, 9'd26)) begin
              state <= S_BIT_SPACE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
            end
          end
          S_BIT_SPACE: begin
            if (in_win(tick_cnt, 9'd6, 9'd26) || in_win(tick_cnt, 9'd38, 9'd58)) begin
              shreg   <= {in_win(tick_cnt, 9'd38, 9'd58), shreg[31:1]};
              bit_cnt <= bit_cnt + 5'd1;
              state   <= (bit_cnt == 5'd31) ? S_DONE : S_BIT_MARK;
            end else begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
            end
          end
          S_DONE: begin
            if (in_win(tick_cnt, 9'd6, 9'd26) && inv_ok) begin
              frame_valid <= 1'b1;
              address     <= EXT_ADDR ? shreg[15:0] : {8'h00, shreg[7:0]};
              command     <= shreg[23:16];
              raw_frame   <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= S_IDLE;
          end
          S_RPT_STOP: begin
            if (in_win(tick_cnt, 9'd6, 9'd26)) begin
              repeat_valid <= win_open;
            end else begin
              frame_err <= 1'b1;
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_rx_param.sv
// Bench for ir_nec_rx_param. Drives NEC waveforms in tick units with a
// scaled-down clock, predicts each output pulse from the protocol rules
// and checks the DUT every cycle against that prediction.
module tb_ir_nec_rx_param;

  localparam int DIV     = 2;    // 100 kHz clock, 20 us tick
  localparam int MS_CYC  = 100;  // cycles per millisecond
  localparam int RPT_MS  = 120;

  localparam int K_NONE  = 0;
  localparam int K_FRAME = 1;
  localparam int K_RPT   = 2;
  localparam int K_ERR   = 3;

  typedef struct {
    int          kind;
    int          lo;
    int          hi;
    logic [15:0] addr;
    logic [7:0]  cmd;
    logic [31:0] raw;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ir_in = 1'b0;
  logic        frame_valid, repeat_valid, frame_err, busy;
  logic [15:0] address;
  logic [7:0]  command;
  logic [31:0] raw_frame;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t expq[$];

  logic [15:0] m_addr = 16'd0;
  logic [7:0]  m_cmd  = 8'd0;
  logic [31:0] m_raw  = 32'd0;
  int          m_win_until = 0;
  int          n_fv = 0, n_rv = 0, n_fe = 0;

  ir_nec_rx_param #(
    .CLK_HZ(100_000), .TICK_NS(20_000), .IR_ACT_LVL(1'b1),
    .CHECK_INV(1'b1), .EXT_ADDR(1'b0), .REPEAT_MS(RPT_MS)
  ) dut (
    .clk_in(clk), .rst_n(rst_n), .ir_in(ir_in),
    .frame_valid(frame_valid), .repeat_valid(repeat_valid),
    .address(address), .command(command), .raw_frame(raw_frame),
    .frame_err(frame_err), .busy(busy)
  );

  // Free-running clock and cycle counter used to time the expected pulses.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic hold(input logic lvl, input int ticks);
    ir_in = lvl;
    repeat (ticks * DIV) @(negedge clk);
  endtask

  // Terminating edge driven now: the pulse shows 4 cycles later (2 sync + edge + output).
  task automatic push_exp(input int kind, input int lo, input int hi, input logic [31:0] w);
    exp_t e;
    e.kind = kind; e.lo = lo; e.hi = hi;
    e.addr = {8'h00, w[7:0]}; e.cmd = w[23:16]; e.raw = w;
    expq.push_back(e);
  endtask

  // kind 0: frame of nbits bits; 1: repeat code; 2: lone mark of nbits ticks
  // ended by a space; 3: mark held for nbits ticks (timeout expected).
  task automatic applyStimulus(input int kind, input logic [31:0] word, input int nbits);
    int c;
    case (kind)
      0: begin
        hold(1'b1, 256);
        hold(1'b0, 128);
        for (int i = 0; i < nbits; i++) begin
          hold(1'b1, 16);
          hold(1'b0, word[i] ? 48 : 16);
        end
        if (nbits == 32) begin
          hold(1'b1, 16);
          ir_in = 1'b0;
          c = cyc;
          if ((word[31:24] != ~word[23:16]) || (word[15:8] != ~word[7:0]))
            push_exp(K_ERR, c + 4, c + 4, word);
          else
            push_exp(K_FRAME, c + 4, c + 4, word);
          hold(1'b0, 40);
        end
      end
      1: begin
        hold(1'b1, 256);
        hold(1'b0, 64);
        hold(1'b1, 16);
        ir_in = 1'b0;
        c = cyc;
        if (c + 4 < m_win_until) push_exp(K_RPT, c + 4, c + 4, {m_cmd ^ 8'hFF, m_cmd, ~m_addr[7:0], m_addr[7:0]});
        hold(1'b0, 40);
      end
      2: begin
        hold(1'b1, nbits);
        ir_in = 1'b0;
        c = cyc;
        push_exp(K_ERR, c + 4, c + 4, 32'd0);
        hold(1'b0, 40);
      end
      default: begin
        c = cyc;
        push_exp(K_ERR, c + 4 + 511 * DIV - DIV, c + 4 + 511 * DIV + DIV, 32'd0);
        hold(1'b1, nbits);
        hold(1'b0, 40);
      end
    endcase
  endtask

  // Compare process: pulse kind and timing against the queue, held data against the model.
  initial begin
    int k;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        k = (int'(frame_valid) + int'(repeat_valid) + int'(frame_err) > 1) ? 7 :
            frame_valid ? K_FRAME : repeat_valid ? K_RPT : frame_err ? K_ERR : K_NONE;
        if (frame_valid)  n_fv++;
        if (repeat_valid) n_rv++;
        if (frame_err)    n_fe++;
        if (expq.size() > 0 && cyc > expq[0].hi) begin
          checkOutput("missed_pulse", k, expq[0].kind);
          void'(expq.pop_front());
        end
        if (k != K_NONE) begin
          if (expq.size() == 0) begin
            checkOutput("unexpected_pulse", k, K_NONE);
          end else if (cyc < expq[0].lo) begin
            checkOutput("early_pulse", k, K_NONE);
          end else begin
            checkOutput("pulse_kind", k, expq[0].kind);
            if (k == expq[0].kind) begin
              if (k == K_FRAME) begin
                m_addr = expq[0].addr; m_cmd = expq[0].cmd; m_raw = expq[0].raw;
              end
              if (k == K_FRAME || k == K_RPT) m_win_until = cyc + RPT_MS * MS_CYC;
              if (k == K_ERR) m_win_until = 0;
            end
            void'(expq.pop_front());
          end
        end
        checkOutput("held_address", {16'd0, address}, {16'd0, m_addr});
        checkOutput("held_command", {24'd0, command}, {24'd0, m_cmd});
        checkOutput("held_raw_frame", raw_frame, m_raw);
      end
    end
  end

  // Directed scenario sequence with literal expectations pinning the model.
  initial begin
    repeat (5) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_pulses", {29'd0, frame_valid, repeat_valid, frame_err}, 32'd0);
    checkOutput("reset_raw", raw_frame, 32'd0);
    rst_n = 1'b1;
    hold(1'b0, 20);

    applyStimulus(0, 32'hE718FF00, 32);
    checkOutput("t1_address", {16'd0, address}, 32'h0000_0000);
    checkOutput("t1_command", {24'd0, command}, 32'h0000_0018);
    checkOutput("t1_raw", raw_frame, 32'hE718FF00);
    checkOutput("t1_frame_count", n_fv, 1);

    hold(1'b0, 2000);
    applyStimulus(1, 32'd0, 0);
    checkOutput("t2_repeat_count", n_rv, 1);
    checkOutput("t2_command", {24'd0, command}, 32'h0000_0018);

    applyStimulus(0, 32'hE718FF00, 32);
    hold(1'b0, 10000);
    applyStimulus(1, 32'd0, 0);
    checkOutput("t3_repeat_count", n_rv, 1);
    checkOutput("t3_err_count", n_fe, 0);

    applyStimulus(0, 32'hE618FF00, 32);
    checkOutput("t4_err_count", n_fe, 1);
    checkOutput("t4_frame_count", n_fv, 2);
    checkOutput("t4_raw_kept", raw_frame, 32'hE718FF00);

    applyStimulus(2, 32'd0, 171);
    checkOutput("t5_short_leader_err", n_fe, 2);
    applyStimulus(3, 32'd0, 571);
    checkOutput("t5_timeout_err", n_fe, 3);
    checkOutput("t5_busy_low", {31'd0, busy}, 32'd0);

    applyStimulus(0, 32'hC33CA55A, 12);
    hold(1'b1, 8);
    checkOutput("t6_busy_mid", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    ir_in = 1'b0;
    expq.delete();
    m_addr = 16'd0; m_cmd = 8'd0; m_raw = 32'd0; m_win_until = 0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("t6_busy_after_reset", {31'd0, busy}, 32'd0);
    checkOutput("t6_raw_after_reset", raw_frame, 32'd0);
    hold(1'b0, 20);
    applyStimulus(0, 32'hC33CA55A, 32);
    checkOutput("t6_address", {16'd0, address}, 32'h0000_005A);
    checkOutput("t6_command", {24'd0, command}, 32'h0000_003C);
    checkOutput("t6_raw", raw_frame, 32'hC33CA55A);

    hold(1'b0, 20);
    checkOutput("pending_expectations", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends even if the sequence stalls.
  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
